// File: rtl/ic_tester_pkg.sv
// ic_tester_pkg: gate type codes, sequencer state encoding and shared timing constants
package ic_tester_pkg;
  localparam logic [2:0] GT_AND  = 3'd0;
  localparam logic [2:0] GT_OR   = 3'd1;
  localparam logic [2:0] GT_NAND = 3'd2;
  localparam logic [2:0] GT_NOR  = 3'd3;
  localparam logic [2:0] GT_XOR  = 3'd4;
  localparam logic [2:0] GT_XNOR = 3'd5;
  localparam int ONE_SECOND_DELAY = 12_500_000;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_SAMPLE, S_DONE} seq_state_t;
endpackage

// File: rtl/gate_identify_sequencer_seq_timer.sv
// seq_timer: loadable down-counter that flags terminal count while it sits at zero
module seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);
  logic [CNT_W-1:0] count;
  assign tc = count == '0;
  // load wins; otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= load ? load_val : (tc ? count : count - 1'b1);
endmodule

// File: rtl/gate_identify_sequencer.sv
// gate_identify_sequencer: scans all gate types on the checker and reports which ones the IC matched
module gate_identify_sequencer
  import ic_tester_pkg::*;
#(
  parameter int NUM_TYPES    = 6,
  parameter int CLEAR_CYCLES = 4,
  parameter int RUN_CYCLES   = 100000002,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           chk_pass,
  input  logic [3:0]           chk_fail,
  output logic                 checker_enable,
  output logic [2:0]           gate_select,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_TYPES-1:0] match_mask,
  output logic                 identified,
  output logic [2:0]           ident_type,
  output logic [3:0]           slot_ok
);
  seq_state_t state, nxt_state;
  logic [2:0] nxt_gsel, nxt_type;
  logic [NUM_TYPES-1:0] nxt_mask;
  logic nxt_id, load, tc, hit;
  logic [3:0] nxt_slot;
  logic [CNT_W-1:0] load_val;
  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .tc(tc)
  );
  // next-state and next-result logic; gate_select doubles as the type under test
  always_comb begin
    nxt_state = state;
    nxt_gsel = gate_select;
    nxt_mask = match_mask;
    nxt_id = identified;
    nxt_type = ident_type;
    nxt_slot = slot_ok;
    load = 1'b0;
    load_val = '0;
    hit = chk_pass == 4'hF && chk_fail == 4'h0;
    if (abort) begin
      nxt_state = S_IDLE;
      nxt_gsel = '0;
      nxt_mask = '0;
      nxt_id = 1'b0;
      nxt_type = '0;
      nxt_slot = 4'hF;
      load = 1'b1;
    end else
      case (state)
        S_IDLE, S_DONE:
          if (start) begin
            nxt_state = S_CLEAR;
            nxt_gsel = '0;
            nxt_mask = '0;
            nxt_id = 1'b0;
            nxt_type = '0;
            nxt_slot = 4'hF;
            load = 1'b1;
            load_val = CNT_W'(CLEAR_CYCLES - 1);
          end
        S_CLEAR:
          if (tc) begin
            nxt_state = S_RUN;
            load = 1'b1;
            load_val = CNT_W'(RUN_CYCLES - 1);
          end
        S_RUN: nxt_state = tc ? S_SAMPLE : S_RUN;
        S_SAMPLE: begin
          nxt_mask[gate_select] = hit;
          nxt_slot = slot_ok & chk_pass;
          if (hit && !identified) begin
            nxt_id = 1'b1;
            nxt_type = gate_select;
          end
          if (gate_select == 3'(NUM_TYPES - 1)) nxt_state = S_DONE;
          else begin
            nxt_state = S_CLEAR;
            nxt_gsel = gate_select + 3'd1;
            load = 1'b1;
            load_val = CNT_W'(CLEAR_CYCLES - 1);
          end
        end
        default: nxt_state = S_IDLE;
      endcase
  end
  // registered outputs; enable stays high through SAMPLE so flags are read before the checker clears
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      checker_enable <= 1'b0;
      gate_select <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      match_mask <= '0;
      identified <= 1'b0;
      ident_type <= '0;
      slot_ok <= 4'hF;
    end else begin
      state <= nxt_state;
      checker_enable <= nxt_state inside {S_RUN, S_SAMPLE};
      gate_select <= nxt_gsel;
      busy <= nxt_state inside {S_CLEAR, S_RUN, S_SAMPLE};
      done <= nxt_state == S_DONE;
      match_mask <= nxt_mask;
      identified <= nxt_id;
      ident_type <= nxt_type;
      slot_ok <= nxt_slot;
    end
endmodule

// File: tb/tb_gate_identify_sequencer.sv
// tb_gate_identify_sequencer: directed scans against a per-gate-type flag model
module tb_gate_identify_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0] chk_pass, chk_fail, slot_ok;
  logic checker_enable, busy, done, identified;
  logic [2:0] gate_select, ident_type;
  logic [5:0] match_mask;
  logic [3:0] pass_tab [8];
  logic [3:0] fail_tab [8];
  int total = 0, bad = 0, cyc = 0, en_cnt = 0;
  logic [2:0] seq [$];

  gate_identify_sequencer #(.NUM_TYPES(6), .CLEAR_CYCLES(2), .RUN_CYCLES(10), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .chk_pass(chk_pass), .chk_fail(chk_fail), .checker_enable(checker_enable),
    .gate_select(gate_select), .busy(busy), .done(done), .match_mask(match_mask),
    .identified(identified), .ident_type(ident_type), .slot_ok(slot_ok)
  );

  always #5 clk = ~clk;
  assign chk_pass = pass_tab[gate_select];
  assign chk_fail = fail_tab[gate_select];

  task automatic set_model(input logic [23:0] p, input logic [23:0] f);
    for (int t = 0; t < 8; t++) begin
      pass_tab[t] = t < 6 ? p[t*4 +: 4] : 4'h0;
      fail_tab[t] = t < 6 ? f[t*4 +: 4] : 4'hF;
    end
  endtask

  task automatic do_scan(input int extra);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    en_cnt = 0;
    seq.delete();
    while (!done && cyc < 200) begin
      if (busy && (seq.size() == 0 || seq[$] !== gate_select)) seq.push_back(gate_select);
      en_cnt += int'(checker_enable);
      start = (cyc == extra);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic check_scan(input string name, input logic [5:0] mask, input logic id,
                            input logic [2:0] ty, input logic [3:0] slot);
    bit ok;
    total++;
    if (cyc !== 78) begin bad++; $display("FAIL %s latency got=%0d exp=78", name, cyc); end
    total++;
    if (match_mask !== mask) begin bad++; $display("FAIL %s match_mask got=%b exp=%b", name, match_mask, mask); end
    total++;
    if (identified !== id) begin bad++; $display("FAIL %s identified got=%b exp=%b", name, identified, id); end
    total++;
    if (ident_type !== ty) begin bad++; $display("FAIL %s ident_type got=%0d exp=%0d", name, ident_type, ty); end
    total++;
    if (slot_ok !== slot) begin bad++; $display("FAIL %s slot_ok got=%b exp=%b", name, slot_ok, slot); end
    total++;
    if ({done, busy, checker_enable} !== 3'b100) begin bad++; $display("FAIL %s done/busy/en got=%b exp=100", name, {done, busy, checker_enable}); end
    total++;
    if (en_cnt !== 66) begin bad++; $display("FAIL %s enable cycles got=%0d exp=66", name, en_cnt); end
    ok = seq.size() == 6;
    for (int i = 0; i < 6 && ok; i++) ok = seq[i] === 3'(i);
    total++;
    if (!ok) begin bad++; $display("FAIL %s gate_select sequence got=%p exp=0..5", name, seq); end
  endtask

  task automatic test_reset();
    bit stayed_idle = 1'b1;
    set_model(24'h000000, 24'hFFFFFF);
    #12;
    total++;
    if ({checker_enable, gate_select, busy, done, match_mask, identified, ident_type, slot_ok} !== {1'b0, 3'd0, 1'b0, 1'b0, 6'd0, 1'b0, 3'd0, 4'hF}) begin
      bad++; $display("FAIL reset outputs got en=%b gs=%0d busy=%b done=%b mask=%b id=%b ty=%0d slot=%b", checker_enable, gate_select, busy, done, match_mask, identified, ident_type, slot_ok);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (checker_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) stayed_idle = 1'b0;
    end
    total++;
    if (!stayed_idle) begin bad++; $display("FAIL idle_no_start got en/busy/done activity exp=none"); end
    total++;
    if ({gate_select, match_mask, identified, slot_ok} !== {3'd0, 6'd0, 1'b0, 4'hF}) begin
      bad++; $display("FAIL idle_hold got gs=%0d mask=%b id=%b slot=%b exp gs=0 mask=0 id=0 slot=1111", gate_select, match_mask, identified, slot_ok);
    end
  endtask

  task automatic test_nand();
    set_model(24'hFFFFFF, 24'hFFF0FF);
    do_scan(-1);
    check_scan("nand", 6'b000100, 1'b1, 3'd2, 4'hF);
  endtask

  task automatic test_xor_xnor();
    set_model(24'hFFFFFF, 24'h00FFFF);
    do_scan(-1);
    check_scan("xor_xnor", 6'b110000, 1'b1, 3'd4, 4'hF);
  endtask

  task automatic test_slot3_fail();
    set_model(24'hBBBBBB, 24'h444444);
    do_scan(-1);
    check_scan("slot3", 6'b000000, 1'b0, 3'd0, 4'b1011);
  endtask

  task automatic test_abort();
    int k = 0;
    set_model(24'hFFFFFF, 24'hFFFFF0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!(gate_select == 3'd3 && checker_enable) && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 100) begin bad++; $display("FAIL abort_reach_run3 got timeout exp=run of type 3"); end
    total++;
    if (match_mask !== 6'b000001) begin bad++; $display("FAIL abort_pre_mask got=%b exp=000001", match_mask); end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    total++;
    if ({checker_enable, busy, done, gate_select, match_mask, identified, slot_ok} !== {1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 4'hF}) begin
      bad++; $display("FAIL abort_state got en=%b busy=%b done=%b gs=%0d mask=%b id=%b slot=%b exp idle/cleared", checker_enable, busy, done, gate_select, match_mask, identified, slot_ok);
    end
    repeat (5) @(negedge clk);
    total++;
    if ({checker_enable, busy} !== 2'b00) begin bad++; $display("FAIL abort_stays_idle got en/busy=%b exp=00", {checker_enable, busy}); end
    do_scan(-1);
    check_scan("after_abort", 6'b000001, 1'b1, 3'd0, 4'hF);
  endtask

  task automatic test_back_to_back();
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    total++;
    if ({done, busy, checker_enable, match_mask, identified} !== {1'b0, 1'b0, 1'b0, 6'd0, 1'b0}) begin
      bad++; $display("FAIL start_abort_in_done got done=%b busy=%b en=%b mask=%b id=%b exp all 0", done, busy, checker_enable, match_mask, identified);
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL start_abort_idle got busy=%b exp=0", busy); end
    set_model(24'hFFFFFF, 24'hFFFFF0);
    do_scan(20);
    check_scan("start_while_busy", 6'b000001, 1'b1, 3'd0, 4'hF);
  endtask

  initial begin
    test_reset();
    test_nand();
    test_xor_xnor();
    test_slot3_fail();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
